// File: rtl/pic_command_sequencer_if.sv
// Write-strobe / configuration bundle between the 8259A bus front end and the
// command sequencer.
interface pic_command_sequencer_if;
    logic [7:0] internal_data_bus;
    logic       write_ICW1;
    logic       write_ICW2_4;
    logic       write_OCW1;
    logic       write_OCW2;
    logic       write_OCW3;

    logic       init_done;
    logic       ltim;
    logic       single;
    logic       ic4;
    logic [4:0] vector_base;
    logic [7:0] cascade_config;
    logic       upm;
    logic       aeoi;
    logic       buf_master;
    logic       buffered_mode;
    logic       sfnm;
    logic [7:0] interrupt_mask;
    logic       auto_rotate;
    logic [2:0] lowest_priority;
    logic       eoi_pulse;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       special_mask_mode;
    logic       read_isr;
    logic       poll_pulse;

    modport master (
        output internal_data_bus, write_ICW1, write_ICW2_4, write_OCW1, write_OCW2, write_OCW3,
        input  init_done, ltim, single, ic4, vector_base, cascade_config, upm, aeoi,
               buf_master, buffered_mode, sfnm, interrupt_mask, auto_rotate,
               lowest_priority, eoi_pulse, eoi_specific, eoi_level,
               special_mask_mode, read_isr, poll_pulse
    );

    modport slave (
        input  internal_data_bus, write_ICW1, write_ICW2_4, write_OCW1, write_OCW2, write_OCW3,
        output init_done, ltim, single, ic4, vector_base, cascade_config, upm, aeoi,
               buf_master, buffered_mode, sfnm, interrupt_mask, auto_rotate,
               lowest_priority, eoi_pulse, eoi_specific, eoi_level,
               special_mask_mode, read_isr, poll_pulse
    );
endinterface

// File: rtl/pic_command_sequencer.sv
// 8259A initialization / operation-command sequencer: walks ICW1..ICW4, then
// turns OCW1-3 writes into configuration registers and one-cycle command pulses.
module pic_command_sequencer (
    input  logic                    clk,
    input  logic                    reset,
    pic_command_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        UNINIT,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_e;

    state_e     state_q;
    logic       ltim_q, single_q, ic4_q;
    logic [4:0] vector_base_q;
    logic [7:0] cascade_config_q;
    logic       upm_q, aeoi_q, buf_master_q, buffered_mode_q, sfnm_q;
    logic [7:0] interrupt_mask_q;
    logic       auto_rotate_q;
    logic [2:0] lowest_priority_q;
    logic       eoi_pulse_q, eoi_specific_q;
    logic [2:0] eoi_level_q;
    logic       special_mask_mode_q, read_isr_q, poll_pulse_q;

    logic [7:0] data;
    logic       a0_write;

    assign data     = bus.internal_data_bus;
    assign a0_write = bus.write_ICW2_4 | bus.write_OCW1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q             <= UNINIT;
            ltim_q              <= 1'b0;
            single_q            <= 1'b0;
            ic4_q               <= 1'b0;
            vector_base_q       <= '0;
            cascade_config_q    <= '0;
            upm_q               <= 1'b0;
            aeoi_q              <= 1'b0;
            buf_master_q        <= 1'b0;
            buffered_mode_q     <= 1'b0;
            sfnm_q              <= 1'b0;
            interrupt_mask_q    <= '0;
            auto_rotate_q       <= 1'b0;
            lowest_priority_q   <= 3'b111;
            eoi_pulse_q         <= 1'b0;
            eoi_specific_q      <= 1'b0;
            eoi_level_q         <= '0;
            special_mask_mode_q <= 1'b0;
            read_isr_q          <= 1'b0;
            poll_pulse_q        <= 1'b0;
        end else begin
            // NOTE: command pulses default low every cycle; a later assignment
            // in this block overrides it (last non-blocking assignment wins).
            eoi_pulse_q    <= 1'b0;
            eoi_specific_q <= 1'b0;
            eoi_level_q    <= '0;
            poll_pulse_q   <= 1'b0;

            if (bus.write_ICW1) begin
                ltim_q              <= data[3];
                single_q            <= data[1];
                ic4_q               <= data[0];
                interrupt_mask_q    <= '0;
                special_mask_mode_q <= 1'b0;
                read_isr_q          <= 1'b0;
                auto_rotate_q       <= 1'b0;
                lowest_priority_q   <= 3'b111;
                upm_q               <= 1'b0;
                aeoi_q              <= 1'b0;
                buf_master_q        <= 1'b0;
                buffered_mode_q     <= 1'b0;
                sfnm_q              <= 1'b0;
                state_q             <= WAIT_ICW2;
            end else begin
                case (state_q)
                    WAIT_ICW2: if (a0_write) begin
                        vector_base_q <= data[7:3];
                        if (!single_q)  state_q <= WAIT_ICW3;
                        else if (ic4_q) state_q <= WAIT_ICW4;
                        else            state_q <= READY;
                    end
                    WAIT_ICW3: if (a0_write) begin
                        cascade_config_q <= data;
                        state_q          <= ic4_q ? WAIT_ICW4 : READY;
                    end
                    WAIT_ICW4: if (a0_write) begin
                        upm_q           <= data[0];
                        aeoi_q          <= data[1];
                        buf_master_q    <= data[2];
                        buffered_mode_q <= data[3];
                        sfnm_q          <= data[4];
                        state_q         <= READY;
                    end
                    READY: begin
                        if (a0_write) begin
                            interrupt_mask_q <= data;
                        end else if (bus.write_OCW2) begin
                            // R/SL/EOI field; rotate-on-non-specific (101) is left to the resolver
                            case (data[7:5])
                                3'b001, 3'b101: eoi_pulse_q <= 1'b1;
                                3'b011: begin
                                    eoi_pulse_q    <= 1'b1;
                                    eoi_specific_q <= 1'b1;
                                    eoi_level_q    <= data[2:0];
                                end
                                3'b111: begin
                                    eoi_pulse_q       <= 1'b1;
                                    eoi_specific_q    <= 1'b1;
                                    eoi_level_q       <= data[2:0];
                                    lowest_priority_q <= data[2:0];
                                end
                                3'b100: auto_rotate_q     <= 1'b1;
                                3'b000: auto_rotate_q     <= 1'b0;
                                3'b110: lowest_priority_q <= data[2:0];
                                default: ;
                            endcase
                        end else if (bus.write_OCW3) begin
                            if (data[6]) special_mask_mode_q <= data[5];
                            if (data[1]) read_isr_q          <= data[0];
                            if (data[2]) poll_pulse_q        <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.init_done         = (state_q == READY);
    assign bus.ltim              = ltim_q;
    assign bus.single            = single_q;
    assign bus.ic4               = ic4_q;
    assign bus.vector_base       = vector_base_q;
    assign bus.cascade_config    = cascade_config_q;
    assign bus.upm               = upm_q;
    assign bus.aeoi              = aeoi_q;
    assign bus.buf_master        = buf_master_q;
    assign bus.buffered_mode     = buffered_mode_q;
    assign bus.sfnm              = sfnm_q;
    assign bus.interrupt_mask    = interrupt_mask_q;
    assign bus.auto_rotate       = auto_rotate_q;
    assign bus.lowest_priority   = lowest_priority_q;
    assign bus.eoi_pulse         = eoi_pulse_q;
    assign bus.eoi_specific      = eoi_specific_q;
    assign bus.eoi_level         = eoi_level_q;
    assign bus.special_mask_mode = special_mask_mode_q;
    assign bus.read_isr          = read_isr_q;
    assign bus.poll_pulse        = poll_pulse_q;
endmodule

// File: tb/tb_pic_command_sequencer.sv
// Self-checking bench for pic_command_sequencer: directed vector table, async
// reset sequence, then random writes against a queue-based behavioural model.
module tb_pic_command_sequencer;
    typedef enum {K_NONE, K_ICW1, K_ICW24, K_OCW1, K_OCW2, K_OCW3} kind_e;
    typedef enum {S_INIT, S_VB, S_CC, S_UPM, S_AEOI, S_IMR, S_LP, S_EOI,
                  S_RISR, S_SMM, S_POLL} sig_e;
    typedef struct {
        kind_e      kind;
        logic [7:0] data;
        sig_e       sig;
        logic [7:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    pic_command_sequencer_if bus_if ();
    pic_command_sequencer dut (.clk(clk), .reset(reset), .bus(bus_if));

    always #5 clk = ~clk;

    // Behavioural model: the ICW words still owed are kept as a queue.
    bit         m_started;
    int         m_pending[$];
    logic       m_ltim, m_single, m_ic4;
    logic [4:0] m_vb;
    logic [7:0] m_cc, m_imr;
    logic [4:0] m_icw4;
    logic       m_arot, m_smm, m_risr;
    logic [2:0] m_lp;
    logic       m_eoi, m_spec, m_poll;
    logic [2:0] m_lvl;

    function automatic bit m_ready();
        return m_started && (m_pending.size() == 0);
    endfunction

    task automatic model_reset();
        m_started = 0; m_pending.delete();
        m_ltim = 0; m_single = 0; m_ic4 = 0; m_vb = 0; m_cc = 0; m_imr = 0;
        m_icw4 = 0; m_arot = 0; m_smm = 0; m_risr = 0; m_lp = 3'd7;
        m_eoi = 0; m_spec = 0; m_poll = 0; m_lvl = 0;
    endtask

    task automatic model_apply(input kind_e k, input logic [7:0] d);
        int w;
        m_eoi = 0; m_spec = 0; m_lvl = 0; m_poll = 0;
        case (k)
            K_ICW1: begin
                m_ltim = d[3]; m_single = d[1]; m_ic4 = d[0];
                m_imr = 0; m_smm = 0; m_risr = 0; m_arot = 0; m_lp = 3'd7; m_icw4 = 0;
                m_pending.delete();
                m_pending.push_back(2);
                if (!m_single) m_pending.push_back(3);
                if (m_ic4)     m_pending.push_back(4);
                m_started = 1;
            end
            K_ICW24, K_OCW1: if (m_started) begin
                if (m_pending.size() == 0) m_imr = d;
                else begin
                    w = m_pending.pop_front();
                    if (w == 2)      m_vb = d[7:3];
                    else if (w == 3) m_cc = d;
                    else             m_icw4 = d[4:0];
                end
            end
            K_OCW2: if (m_ready()) begin
                // d[7]=R, d[6]=SL, d[5]=EOI
                if (d[5]) begin
                    m_eoi = 1; m_spec = d[6]; m_lvl = d[6] ? d[2:0] : 3'd0;
                    if (d[7] && d[6]) m_lp = d[2:0];
                end else if (d[7] && d[6]) m_lp = d[2:0];
                else if (!d[6]) m_arot = d[7];
            end
            K_OCW3: if (m_ready()) begin
                if (d[6]) m_smm = d[5];
                if (d[1]) m_risr = d[0];
                if (d[2]) m_poll = 1;
            end
            default: ;
        endcase
    endtask

    function automatic logic [63:0] pack_model();
        return 64'({m_ready(), m_ltim, m_single, m_ic4, m_vb, m_cc, m_icw4[0], m_icw4[1],
                    m_icw4[2], m_icw4[3], m_icw4[4], m_imr, m_arot, m_lp, m_eoi, m_spec,
                    m_lvl, m_smm, m_risr, m_poll});
    endfunction

    function automatic logic [63:0] pack_dut();
        return 64'({bus_if.init_done, bus_if.ltim, bus_if.single, bus_if.ic4,
                    bus_if.vector_base, bus_if.cascade_config, bus_if.upm, bus_if.aeoi,
                    bus_if.buf_master, bus_if.buffered_mode, bus_if.sfnm,
                    bus_if.interrupt_mask, bus_if.auto_rotate, bus_if.lowest_priority,
                    bus_if.eoi_pulse, bus_if.eoi_specific, bus_if.eoi_level,
                    bus_if.special_mask_mode, bus_if.read_isr, bus_if.poll_pulse});
    endfunction

    function automatic logic [7:0] get_sig(input sig_e s);
        case (s)
            S_INIT: return 8'(bus_if.init_done);
            S_VB:   return 8'(bus_if.vector_base);
            S_CC:   return bus_if.cascade_config;
            S_UPM:  return 8'(bus_if.upm);
            S_AEOI: return 8'(bus_if.aeoi);
            S_IMR:  return bus_if.interrupt_mask;
            S_LP:   return 8'(bus_if.lowest_priority);
            S_EOI:  return 8'({bus_if.eoi_pulse, bus_if.eoi_specific, bus_if.eoi_level});
            S_RISR: return 8'(bus_if.read_isr);
            S_SMM:  return 8'(bus_if.special_mask_mode);
            default: return 8'(bus_if.poll_pulse);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One bus write: strobe high across exactly one rising edge, outputs compared #1 later.
    task automatic step(input kind_e k, input logic [7:0] d);
        @(negedge clk);
        bus_if.internal_data_bus = d;
        bus_if.write_ICW1   = (k == K_ICW1);
        bus_if.write_ICW2_4 = (k == K_ICW24);
        bus_if.write_OCW1   = (k == K_OCW1);
        bus_if.write_OCW2   = (k == K_OCW2);
        bus_if.write_OCW3   = (k == K_OCW3);
        @(posedge clk);
        #1;
        bus_if.write_ICW1 = 0; bus_if.write_ICW2_4 = 0; bus_if.write_OCW1 = 0;
        bus_if.write_OCW2 = 0; bus_if.write_OCW3 = 0;
        model_apply(k, d);
        check($sformatf("model %s 0x%02h", k.name(), d), pack_dut(), pack_model());
    endtask

    vec_t vecs[$];

    initial begin
        bus_if.internal_data_bus = 0;
        bus_if.write_ICW1 = 0; bus_if.write_ICW2_4 = 0; bus_if.write_OCW1 = 0;
        bus_if.write_OCW2 = 0; bus_if.write_OCW3 = 0;
        model_reset();

        vecs.push_back('{K_ICW1,  8'h13, S_INIT, 8'h00});
        vecs.push_back('{K_ICW24, 8'h40, S_VB,   8'h08});
        vecs.push_back('{K_ICW24, 8'h03, S_INIT, 8'h01});
        vecs.push_back('{K_NONE,  8'h00, S_AEOI, 8'h01});
        vecs.push_back('{K_NONE,  8'h00, S_UPM,  8'h01});
        vecs.push_back('{K_ICW1,  8'h11, S_AEOI, 8'h00});
        vecs.push_back('{K_ICW24, 8'h20, S_VB,   8'h04});
        vecs.push_back('{K_ICW24, 8'h04, S_CC,   8'h04});
        vecs.push_back('{K_ICW24, 8'h01, S_INIT, 8'h01});
        vecs.push_back('{K_OCW1,  8'hFB, S_IMR,  8'hFB});
        vecs.push_back('{K_NONE,  8'h00, S_AEOI, 8'h00});
        vecs.push_back('{K_OCW2,  8'h63, S_EOI,  8'h1B});
        vecs.push_back('{K_NONE,  8'h00, S_EOI,  8'h00});
        vecs.push_back('{K_OCW2,  8'hC5, S_LP,   8'h05});
        vecs.push_back('{K_OCW3,  8'h0B, S_RISR, 8'h01});
        vecs.push_back('{K_OCW3,  8'h68, S_SMM,  8'h01});
        vecs.push_back('{K_NONE,  8'h00, S_RISR, 8'h01});
        vecs.push_back('{K_OCW3,  8'h0C, S_POLL, 8'h01});
        vecs.push_back('{K_NONE,  8'h00, S_POLL, 8'h00});
        vecs.push_back('{K_ICW1,  8'h11, S_INIT, 8'h00});
        vecs.push_back('{K_OCW2,  8'h20, S_EOI,  8'h00});
        vecs.push_back('{K_ICW24, 8'h20, S_INIT, 8'h00});
        vecs.push_back('{K_ICW1,  8'h12, S_IMR,  8'h00});
        vecs.push_back('{K_ICW24, 8'h08, S_INIT, 8'h01});
        vecs.push_back('{K_NONE,  8'h00, S_UPM,  8'h00});
        vecs.push_back('{K_NONE,  8'h00, S_AEOI, 8'h00});
        vecs.push_back('{K_NONE,  8'h00, S_VB,   8'h01});
        vecs.push_back('{K_OCW1,  8'hFF, S_IMR,  8'hFF});

        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        check("reset_state", pack_dut(), pack_model());
        check("reset_lowest_priority", 64'(bus_if.lowest_priority), 64'd7);

        foreach (vecs[i]) begin
            step(vecs[i].kind, vecs[i].data);
            check($sformatf("vec%0d %s", i, vecs[i].sig.name()),
                  64'(get_sig(vecs[i].sig)), 64'(vecs[i].exp));
        end

        // Asynchronous reset mid-cycle from READY with IMR=0xFF.
        @(negedge clk);
        #1 reset = 1;
        #1;
        model_reset();
        check("async_reset_all", pack_dut(), pack_model());
        check("async_reset_init_done", 64'(bus_if.init_done), 64'd0);
        check("async_reset_imr", 64'(bus_if.interrupt_mask), 64'd0);
        @(negedge clk);
        reset = 0;
        step(K_ICW24, 8'hA5);
        check("a0_ignored_in_uninit", 64'(bus_if.vector_base), 64'd0);

        for (int n = 0; n < 800; n++) begin
            int    r;
            kind_e k;
            logic [7:0] d;
            r = int'($urandom_range(0, 99));
            d = 8'($urandom);
            if (r < 6)       k = K_ICW1;
            else if (r < 25) k = K_ICW24;
            else if (r < 45) k = K_OCW1;
            else if (r < 68) k = K_OCW2;
            else if (r < 88) k = K_OCW3;
            else             k = K_NONE;
            step(k, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pic_command_sequencer.md
# pic_command_sequencer

Clocked initialization and command sequencer for the 8259A-compatible PIC. It consumes the decoded write strobes and latched data byte from the data bus buffer / read-write logic. It steps through the ICW1→ICW2→(ICW3)→(ICW4) initialization sequence, then routes A0=1 writes to the interrupt mask (OCW1). It decodes OCW2/OCW3 into configuration registers and one-cycle command pulses for the priority resolver, in-service logic and cascade logic.

## Interface
- No parameters; the PIC is fixed at 8 IR lines.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1 — system clock; all state changes on the rising edge.
- `reset` in 1 — asynchronous, active-high; forces every register to its reset value.
- `internal_data_bus` in 8 — byte latched by the bus buffer; stable while any strobe is high.
- `write_ICW1`, `write_ICW2_4`, `write_OCW1`, `write_OCW2`, `write_OCW3` in 1 each — write strobes; each is high for exactly one `clk` cycle per bus write. `write_ICW2_4` and `write_OCW1` are the same A0=1 event and are used ORed as `a0_write`.
- `init_done` out 1 — high in READY.
- `ltim` out 1 — ICW1 D3: level-triggered mode.
- `single` out 1 — ICW1 D1.
- `ic4` out 1 — ICW1 D0.
- `vector_base` out 5 — ICW2 D7:D3.
- `cascade_config` out 8 — ICW3 byte: slave mask when master, ID in bits 2:0 when slave.
- `upm` out 1 — ICW4 D0.
- `aeoi` out 1 — ICW4 D1.
- `buf_master` out 1 — ICW4 D2.
- `buffered_mode` out 1 — ICW4 D3.
- `sfnm` out 1 — ICW4 D4.
- `interrupt_mask` out 8 — OCW1 (IMR).
- `auto_rotate` out 1 — rotate-in-AEOI mode flag.
- `lowest_priority` out 3 — IR level currently holding lowest priority.
- `eoi_pulse` out 1 — one-cycle end-of-interrupt command.
- `eoi_specific` out 1 — valid with `eoi_pulse`; 1 = specific EOI.
- `eoi_level` out 3 — valid with `eoi_pulse` when specific.
- `special_mask_mode` out 1 — SMM flag.
- `read_isr` out 1 — 1 selects ISR, 0 selects IRR for status reads.
- `poll_pulse` out 1 — one-cycle poll command.

## Operation
- States: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- `write_ICW1` in any state (including mid-sequence):
  - load `ltim`, `single`, `ic4`;
  - clear `interrupt_mask`, `special_mask_mode`, `read_isr`, `auto_rotate`;
  - set `lowest_priority` = 7;
  - clear `upm`, `aeoi`, `buf_master`, `buffered_mode`, `sfnm` (these stay 0 if ICW4 is skipped);
  - go to WAIT_ICW2.
- `a0_write` in WAIT_ICW2: load `vector_base` = D7:D3. Next state: WAIT_ICW3 if `single`=0, else WAIT_ICW4 if `ic4`=1, else READY.
- `a0_write` in WAIT_ICW3: load `cascade_config`. Next state: WAIT_ICW4 if `ic4`, else READY.
- `a0_write` in WAIT_ICW4: load ICW4 fields. Next state: READY.
- `a0_write` in READY: `interrupt_mask` ← byte.
- `a0_write` in UNINIT: ignored.
- `write_OCW2` / `write_OCW3` are ignored in every state except READY.
- OCW2 decode, R/SL/EOI = D7:D5, L = D2:D0:
  - 001: non-specific EOI pulse.
  - 011: specific EOI pulse with `eoi_level`=L.
  - 101: non-specific EOI pulse and `lowest_priority` ← `eoi_level_in_service`. No such input exists, so the rotation is signalled by the EOI pulse alone and the priority resolver performs it.
  - 111: specific EOI pulse and `lowest_priority` ← L.
  - 100: `auto_rotate` ← 1.
  - 000: `auto_rotate` ← 0.
  - 110: `lowest_priority` ← L, no EOI.
  - 010: no-op.
- OCW3 decode:
  - D6=1: `special_mask_mode` ← D5.
  - D1=1: `read_isr` ← D0.
  - D2=1: `poll_pulse`.
  - D2 and D1 are independent; both can act in the same write.
- Simultaneous strobes: `write_ICW1` wins over everything. The upstream decode makes other combinations mutually exclusive; any such combination is otherwise ignored.

## Timing
- Strobes are sampled on the rising `clk` edge. Registered outputs and state update at that edge and are visible in the next cycle (latency 1).
- `eoi_pulse`, `eoi_specific`, `eoi_level` and `poll_pulse` are high for exactly one cycle, the cycle after the strobe edge. `eoi_specific` and `eoi_level` return to 0 when there is no pulse.
- Back-to-back strobes on consecutive cycles are each processed; no dead cycle.
- Reset values:
  - state UNINIT;
  - `lowest_priority` = 3'b111;
  - every other output 0.
- Reset mid-sequence returns to UNINIT immediately and asynchronously.

## Test plan
- Reset, then ICW1=0x13 (single, IC4), ICW2=0x40, ICW4=0x03. Required: ICW3 skipped; `vector_base`=0x08, `aeoi`=1, `upm`=1; `init_done`=1 one cycle after the ICW4 strobe.
- ICW1=0x11 (cascade, IC4), ICW2=0x20, ICW3=0x04, ICW4=0x01, then A0 write 0xFB. Required: `cascade_config`=0x04, `interrupt_mask`=0xFB, `aeoi`=0.
- In READY, OCW2=0x63. Required: one-cycle `eoi_pulse`=1, `eoi_specific`=1, `eoi_level`=3. Then OCW2=0xC5 → `lowest_priority`=5, no pulse.
- OCW3=0x0B → `read_isr`=1. Then OCW3=0x68 → `special_mask_mode`=1, `read_isr` still 1. Then OCW3=0x0C → `poll_pulse` for one cycle.
- In WAIT_ICW3, issue ICW1=0x12 (single, no IC4), then ICW2=0x08. Required: restart; `interrupt_mask`=0; READY directly after ICW2; `upm`/`aeoi`=0. Also, OCW2 issued during WAIT_ICW2 produces no pulse.
- Assert `reset` asynchronously while in READY with IMR=0xFF. Required: all outputs at reset values before the next clock edge; `init_done`=0.
